// File: rtl/dff_if.sv
// Data-side bundle for the dff_reg leaf register; clk and rst stay plain ports on the block.
// With DFF_SAMPLE_CNT_EN defined the bundle also carries the 16-bit sample counter.
interface dff_if #(
    parameter int WIDTH = 1
) ();
    logic [WIDTH-1:0] din;
    logic             ce;
    logic [WIDTH-1:0] dout;
    logic             chg;
`ifdef DFF_SAMPLE_CNT_EN
    logic [15:0]      sample_cnt;
`endif

`ifdef DFF_SAMPLE_CNT_EN
    modport master (output din, output ce, input dout, input chg, input sample_cnt);
    modport slave  (input din, input ce, output dout, output chg, output sample_cnt);
`else
    modport master (output din, output ce, input dout, input chg);
    modport slave  (input din, input ce, output dout, output chg);
`endif
endinterface

// File: rtl/dff_reg.sv
// Single-stage registered flip-flop with clock enable, change flag and synchronous active-high reset.
// Optional feature macro DFF_SAMPLE_CNT_EN adds a saturating 16-bit count of enabled captures.
module dff_reg #(
    parameter int          WIDTH       = 1,
    parameter logic [63:0] RESET_VALUE = '0
) (
    input  logic clk,
    input  logic rst,
    dff_if.slave bus
);
    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             chg_q, chg_d;

    // chg compares against the pre-edge dout, so it flags real transitions only
    always_comb begin
        dout_d = dout_q;
        chg_d  = 1'b0;
        if (bus.ce) begin
            dout_d = bus.din;
            chg_d  = (bus.din != dout_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= RST_VAL;
            chg_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            chg_q  <= chg_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.chg  = chg_q;

`ifdef DFF_SAMPLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturates rather than wraps so a long run never reads as a short one
    always_comb begin
        cnt_d = cnt_q;
        if (bus.ce && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

    assign bus.sample_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_dff_reg.sv
// Self-checking bench for dff_reg: a 1-bit default instance and an 8-bit instance with reset value A5.
module tb_dff_reg;
    logic clk = 1'b0;
    logic rst, rst8;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dff_if #(.WIDTH(1)) b1 ();
    dff_if #(.WIDTH(8)) b8 ();

    dff_reg #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .bus(b1));
    dff_reg #(.WIDTH(8), .RESET_VALUE(64'hA5)) dut8 (.clk(clk), .rst(rst8), .bus(b8));

    // Drive on the falling edge, then return 1 time unit after the capturing edge
    task automatic cyc(input logic r, input logic c, input logic d);
        @(negedge clk);
        rst = r; b1.ce = c; b1.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc8(input logic r, input logic c, input logic [7:0] d);
        @(negedge clk);
        rst8 = r; b8.ce = c; b8.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            n_checks++;
            if (b1.dout !== 1'b0 || b1.chg !== 1'b0) begin
                n_fail++;
                $display("FAIL reset edge %0d: dout=%b chg=%b expected dout=0 chg=0", i, b1.dout, b1.chg);
            end
        end
        cyc(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (b1.dout !== 1'b1 || b1.chg !== 1'b1) begin
            n_fail++;
            $display("FAIL reset release: dout=%b chg=%b expected dout=1 chg=1", b1.dout, b1.chg);
        end
    endtask

    task automatic test_random_stream;
        logic q[$];
        logic prev, d, exp_v;
        int   mism = 0;
        cyc(1'b1, 1'b1, 1'b0);
        prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            d = 1'($urandom);
            q.push_back(d);
            cyc(1'b0, 1'b1, d);
            exp_v = q.pop_front();
            n_checks++;
            if (b1.dout !== exp_v || b1.chg !== (exp_v != prev)) begin
                n_fail++; mism++;
                $display("FAIL stream[%0d]: dout=%b chg=%b expected dout=%b chg=%b",
                         i, b1.dout, b1.chg, exp_v, exp_v != prev);
            end
            prev = exp_v;
        end
        n_checks++;
        if (mism !== 0) begin
            n_fail++;
            $display("FAIL stream scoreboard: mismatches=%0d expected 0", mism);
        end
    endtask

    task automatic test_mid_reset;
        logic din_s[3] = '{1'b1, 1'b0, 1'b1};
        logic rst_s[3] = '{1'b0, 1'b1, 1'b0};
        logic exp_d[3] = '{1'b1, 1'b0, 1'b1};
        logic exp_c[3] = '{1'b1, 1'b0, 1'b1};
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(rst_s[i], 1'b1, din_s[i]);
            n_checks++;
            if (b1.dout !== exp_d[i] || b1.chg !== exp_c[i]) begin
                n_fail++;
                $display("FAIL midreset[%0d]: dout=%b chg=%b expected dout=%b chg=%b",
                         i, b1.dout, b1.chg, exp_d[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_hold;
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (b1.dout !== 1'b1 || b1.chg !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: dout=%b chg=%b expected dout=1 chg=0", i, b1.dout, b1.chg);
            end
        end
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (b1.dout !== 1'b0 || b1.chg !== 1'b1) begin
            n_fail++;
            $display("FAIL hold release: dout=%b chg=%b expected dout=0 chg=1", b1.dout, b1.chg);
        end
    endtask

    task automatic test_wide;
        logic [7:0] m, d;
        logic       r, c, mc;
        cyc8(1'b1, 1'b1, 8'h3C);
        n_checks++;
        if (b8.dout !== 8'hA5 || b8.chg !== 1'b0) begin
            n_fail++;
            $display("FAIL wide reset: dout=%h chg=%b expected dout=a5 chg=0", b8.dout, b8.chg);
        end
        cyc8(1'b0, 1'b1, 8'h3C);
        n_checks++;
        if (b8.dout !== 8'h3C || b8.chg !== 1'b1) begin
            n_fail++;
            $display("FAIL wide load: dout=%h chg=%b expected dout=3c chg=1", b8.dout, b8.chg);
        end
        cyc8(1'b0, 1'b1, 8'h3C);
        n_checks++;
        if (b8.dout !== 8'h3C || b8.chg !== 1'b0) begin
            n_fail++;
            $display("FAIL wide repeat: dout=%h chg=%b expected dout=3c chg=0", b8.dout, b8.chg);
        end
        // Random rst/ce/din mix against the behavioural rules
        m = 8'h3C;
        for (int i = 0; i < 40; i++) begin
            r = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 3) != 0);
            d = (i % 5 == 0) ? m : 8'($urandom);
            cyc8(r, c, d);
            if (r)      begin mc = 1'b0;   m = 8'hA5; end
            else if (c) begin mc = (d != m); m = d;   end
            else              mc = 1'b0;
            n_checks++;
            if (b8.dout !== m || b8.chg !== mc) begin
                n_fail++;
                $display("FAIL wide mix[%0d] rst=%b ce=%b: dout=%h chg=%b expected dout=%h chg=%b",
                         i, r, c, b8.dout, b8.chg, m, mc);
            end
        end
    endtask

`ifdef DFF_SAMPLE_CNT_EN
    task automatic test_sample_cnt;
        logic [15:0] exp_seq[4] = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'($urandom));
        n_checks++;
        if (b1.sample_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL cnt enabled: sample_cnt=%0d expected 5", b1.sample_cnt);
        end
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (b1.sample_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL cnt hold: sample_cnt=%0d expected 5", b1.sample_cnt);
        end
        cyc(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (b1.sample_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt reset: sample_cnt=%0d expected 0", b1.sample_cnt);
        end
        @(negedge clk);
        rst = 1'b0; b1.ce = 1'b0;
        force dut.cnt_q = 16'hFFFD;
        #1;
        release dut.cnt_q;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (b1.sample_cnt !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL cnt saturate[%0d]: sample_cnt=%h expected %h", i, b1.sample_cnt, exp_seq[i]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; b1.ce = 1'b1; b1.din = 1'b0;
        rst8 = 1'b1; b8.ce = 1'b1; b8.din = 8'h00;
        test_reset();
        test_random_stream();
        test_mid_reset();
        test_hold();
        test_wide();
`ifdef DFF_SAMPLE_CNT_EN
        test_sample_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
